// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one active-low digit enable per scan slot,
// with frame-snapshotted inputs, blink and blank control, and a frame-start pulse.
module seg_scan_driver #(
   parameter int N_DIGITS     = 8,
   parameter int SCAN_DIV     = 100,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  fs,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic [N_DIGITS-1:0]   blank_mask,
   input  logic [N_DIGITS-1:0]   dp_mask,
   output logic [N_DIGITS-1:0]   led_dig,
   output logic [7:0]            display,
   output logic                  frame_start
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(N_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Blank beats blink; blink only darkens during the odd blink phase.
   function automatic logic [7:0] seg_value(input logic blank, input logic blink,
                                            input logic phase, input logic dp,
                                            input logic [3:0] v);
      logic [7:0] s;
      if (blank)               s = 8'hFF;
      else if (blink && phase) s = 8'hFF;
      else                     s = {~dp, seg_decode(v)};
      return s;
   endfunction

   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;
   logic [FW-1:0]         r_frame;
   logic                  r_phase;
   logic [4*N_DIGITS-1:0] r_digits;
   logic [N_DIGITS-1:0]   r_blink;
   logic [N_DIGITS-1:0]   r_blank;
   logic [N_DIGITS-1:0]   r_dp;
   logic [N_DIGITS-1:0]   r_led_dig;
   logic [7:0]            r_display;
   logic                  r_frame_start;

   logic                  w_tick;
   logic                  w_wrap;
   logic [IW-1:0]         w_idx_nxt;
   logic [4*N_DIGITS-1:0] w_src_digits;
   logic [N_DIGITS-1:0]   w_src_blink;
   logic [N_DIGITS-1:0]   w_src_blank;
   logic [N_DIGITS-1:0]   w_src_dp;
   logic [3:0]            w_digit_val;
   logic [7:0]            w_seg_nxt;
   logic [N_DIGITS-1:0]   w_led_nxt;

   assign w_tick    = (r_presc == P_LAST);
   assign w_wrap    = w_tick && (r_idx == I_LAST);
   assign w_idx_nxt = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;

   // On the wrap tick digit 0 must already see the fresh snapshot, so bypass the registers.
   assign w_src_digits = w_wrap ? digits     : r_digits;
   assign w_src_blink  = w_wrap ? blink_mask : r_blink;
   assign w_src_blank  = w_wrap ? blank_mask : r_blank;
   assign w_src_dp     = w_wrap ? dp_mask    : r_dp;

   assign w_digit_val = w_src_digits[{w_idx_nxt, 2'b00} +: 4];
   assign w_seg_nxt   = seg_value(w_src_blank[w_idx_nxt], w_src_blink[w_idx_nxt],
                                  r_phase, w_src_dp[w_idx_nxt], w_digit_val);
   assign w_led_nxt   = ~(N_DIGITS'(1) << w_idx_nxt);

   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= I_LAST;
      end else if (w_tick) begin
         r_presc <= '0;
         r_idx   <= w_idx_nxt;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         r_frame <= '0;
         r_phase <= 1'b0;
      end else if (w_wrap) begin
         if (r_frame == F_LAST) begin
            r_frame <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_frame <= r_frame + 1'b1;
         end
      end
   end

   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         r_digits <= '0;
         r_blink  <= '0;
         r_blank  <= '0;
         r_dp     <= '0;
      end else if (w_wrap) begin
         r_digits <= digits;
         r_blink  <= blink_mask;
         r_blank  <= blank_mask;
         r_dp     <= dp_mask;
      end
   end

   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         r_led_dig     <= '1;
         r_display     <= 8'hFF;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_wrap;
         if (w_tick) begin
            r_led_dig <= w_led_nxt;
            r_display <= w_seg_nxt;
         end
      end
   end

   assign led_dig     = r_led_dig;
   assign display     = r_display;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with N_DIGITS=8, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_driver;

   logic        fs;
   logic        rst;
   logic [31:0] digits;
   logic [7:0]  blink_mask;
   logic [7:0]  blank_mask;
   logic [7:0]  dp_mask;
   logic [7:0]  led_dig;
   logic [7:0]  display;
   logic        frame_start;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   seg_scan_driver #(.N_DIGITS(8), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .fs          (fs),
      .rst         (rst),
      .digits      (digits),
      .blink_mask  (blink_mask),
      .blank_mask  (blank_mask),
      .dp_mask     (dp_mask),
      .led_dig     (led_dig),
      .display     (display),
      .frame_start (frame_start)
   );

   initial fs = 1'b0;
   always #5 fs = ~fs;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after rising edge number c since the last reset release.
   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge fs);
         cyc++;
      end
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      digits     = 32'h76543210;
      blink_mask = 8'h00;
      blank_mask = 8'h00;
      dp_mask    = 8'h00;
      repeat (2) @(posedge fs);
      #1;
      chk("rst_led", led_dig, 8'hFF);
      chk("rst_disp", display, 8'hFF);
      chk("rst_fs", {7'd0, frame_start}, 8'h00);

      rst = 1'b0;
      cyc = 0;
      go(3);
      chk("pre_tick_led", led_dig, 8'hFF);
      chk("pre_tick_fs", {7'd0, frame_start}, 8'h00);
      go(4);
      chk("c4_led", led_dig, 8'hFE);
      chk("c4_disp", display, 8'hC0);
      chk("c4_fs", {7'd0, frame_start}, 8'h01);
      go(5);
      chk("c5_fs", {7'd0, frame_start}, 8'h00);
      chk("c5_led", led_dig, 8'hFE);
      go(8);
      chk("c8_led", led_dig, 8'hFD);
      chk("c8_disp", display, 8'hF9);
      chk("c8_fs", {7'd0, frame_start}, 8'h00);
      go(16);
      chk("c16_led", led_dig, 8'hF7);
      chk("c16_disp", display, 8'hB0);

      go(17);
      digits = 32'hFFFFFFFF;
      go(20);
      chk("tear_d4", display, 8'h99);
      chk("tear_led4", led_dig, 8'hEF);
      go(24);
      chk("tear_d5", display, 8'h92);
      go(28);
      chk("tear_d6", display, 8'h82);
      go(32);
      chk("tear_d7", display, 8'hF8);
      go(36);
      chk("f1_led", led_dig, 8'hFE);
      chk("f1_d0", display, 8'h8E);
      chk("f1_fs", {7'd0, frame_start}, 8'h01);
      go(40);
      chk("f1_d1", display, 8'h8E);

      go(41);
      blink_mask = 8'h01;
      go(68);
      chk("blink_f2_d0", display, 8'hFF);
      chk("blink_f2_led", led_dig, 8'hFE);
      go(72);
      chk("blink_f2_d1", display, 8'h8E);
      go(100);
      chk("blink_f3_d0", display, 8'hFF);
      go(132);
      chk("blink_f4_d0", display, 8'h8E);

      go(140);
      blank_mask = 8'h01;
      go(164);
      chk("blank_f5_d0", display, 8'hFF);
      go(168);
      chk("blank_f5_d1", display, 8'h8E);
      go(196);
      chk("blank_f6_d0", display, 8'hFF);

      go(197);
      blank_mask = 8'h00;
      blink_mask = 8'h00;
      dp_mask    = 8'h04;
      digits     = 32'h76543810;
      go(228);
      chk("dp_f7_d0", display, 8'hC0);
      go(236);
      chk("dp_led2", led_dig, 8'hFB);
      chk("dp_d2", display, 8'h00);
      go(240);
      chk("dp_d3", display, 8'hB0);
      go(248);
      chk("mid_led5", led_dig, 8'hDF);
      chk("mid_d5", display, 8'h92);

      go(249);
      rst = 1'b1;
      #1;
      chk("async_led", led_dig, 8'hFF);
      chk("async_disp", display, 8'hFF);
      @(posedge fs);
      #1;
      rst = 1'b0;
      cyc = 0;
      go(3);
      chk("rr_c3_led", led_dig, 8'hFF);
      go(4);
      chk("rr_c4_led", led_dig, 8'hFE);
      chk("rr_c4_disp", display, 8'hC0);
      chk("rr_c4_fs", {7'd0, frame_start}, 8'h01);
      go(8);
      chk("rr_c8_led", led_dig, 8'hFD);
      chk("rr_c8_disp", display, 8'hF9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 100: fs cycles each digit stays enabled, legal range 2..65535.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink-phase toggle, legal range 1..1023.
REQ-004 fs  in  1: single clock; every flop is posedge fs.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 digits  in  4*N_DIGITS: hex value per digit; digit k is digits[4k+3:4k].
REQ-007 blink_mask  in  N_DIGITS: bit k=1 makes digit k blink.
REQ-008 blank_mask  in  N_DIGITS: bit k=1 forces digit k dark; it overrides blink.
REQ-009 dp_mask  in  N_DIGITS: bit k=1 lights the decimal point of digit k.
REQ-010 led_dig  out  N_DIGITS: digit enables, active-low, one-cold.
REQ-011 display  out  8: {dp,g,f,e,d,c,b,a}, all active-low.
REQ-012 frame_start  out  1: one-cycle pulse when digit 0 is enabled.

Function
REQ-013 The prescaler shall count 0..SCAN_DIV-1 and wrap; the cycle at SCAN_DIV-1 is the tick.
REQ-014 On each tick the scan index shall advance by one and wrap from N_DIGITS-1 to 0.
REQ-015 led_dig and display shall be registered and shall update only on the tick, showing the new index.
REQ-016 led_dig shall drive bit idx low and all other bits high, so exactly one digit is enabled after the first tick.
REQ-017 On the tick where the index wraps to 0, digits, blink_mask, blank_mask and dp_mask shall be snapshotted, and that digit-0 output shall already use the new snapshot.
REQ-018 Between snapshots, input changes shall not affect outputs; this gives tear-free frames.
REQ-019 The frame counter shall increment on each wrap to 0; on reaching BLINK_FRAMES-1 it shall clear and toggle blink_phase.
REQ-020 Segment value, priority high to low: blank bit = 8'hFF; blink bit with blink_phase=1 = 8'hFF; otherwise decode with dp = ~dp_mask bit.
REQ-021 Decode for g..a, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 frame_start shall be 1 for exactly the fs cycle after the tick that selects index 0, and 0 otherwise.
REQ-023 Counter widths shall be sized from the parameters using clog2, and no counter shall exceed its terminal value.

Reset
REQ-024 While rst=1, or asynchronously on assertion: led_dig all ones, display 8'hFF, frame_start 0, prescaler 0, index N_DIGITS-1, frame counter 0, blink_phase 0, snapshots 0.
REQ-025 After release, the first tick shall fall SCAN_DIV cycles later, shall select digit 0 and take a snapshot.
REQ-026 If rst is asserted mid-frame, outputs shall go dark immediately, and scanning shall restart at REQ-025 with no partial frame.

Verification (N_DIGITS=8, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 Scenario: release rst, digits=32'h76543210, masks 0 -> at cycle 4, led_dig=8'hFE, display=8'hC0, frame_start=1 for one cycle; at cycle 8, led_dig=8'hFD, display=8'hF9; at cycle 36, led_dig is 8'hFE again.
REQ-028 Scenario: change digits to 32'hFFFFFFFF while digit 3 is active -> digits 4..7 still show 4..7; the next frame shows F (8'h8E) on all digits.
REQ-029 Scenario: blink_mask=8'h01 -> digit 0 is lit in frames 0-1, 8'hFF in frames 2-3, and lit in frames 4-5; other digits are unaffected.
REQ-030 Scenario: blank_mask=8'h01 and blink_mask=8'h01 -> digit 0 is 8'hFF in every frame.
REQ-031 Scenario: dp_mask=8'h04, digit 2=8 -> display=8'h00 while led_dig=8'hFB.
REQ-032 Scenario: rst pulsed while digit 5 is active -> same cycle, led_dig=8'hFF and display=8'hFF; 4 cycles after release, led_dig=8'hFE.
